// File: rtl/tick_pwm.sv
// -----------------------------------------------------------------------------
// tick_pwm
//
// Programmable PWM generator. It runs on the system clock and is advanced by a
// divided clock from the divider stage. Rising edges of div_clk_in become
// single-cycle ticks. The ticks step a counter through a programmable period,
// and pwm_out is high while the counter is below the programmable duty.
//
// New settings arrive on a valid/ready handshake. In IDLE a nonzero period
// starts the generator at once. In RUN the settings wait in a shadow register
// and are copied to the active set only at a period boundary, so the waveform
// never changes mid-period. If the shadow period is 0, the generator returns
// to IDLE at the next boundary.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   div_clk_in   divided clock from the divider stage
//   enable       1 = ticks advance the counter, 0 = counter frozen
//   cfg_valid    configuration offered
//   cfg_ready    configuration can be accepted
//   cfg_period   ticks per PWM period (0 = stop)
//   cfg_duty     ticks of high output per period
//   pwm_out      PWM waveform
//   period_done  one-cycle pulse after each period boundary
//   active       1 while running
// -----------------------------------------------------------------------------
module tick_pwm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             div_clk_in,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [WIDTH-1:0] cfg_duty,
   output logic             pwm_out,
   output logic             period_done,
   output logic             active
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic             div_d;
   logic             tick;
   logic             xfer;
   logic             boundary;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] period_a, duty_a;
   logic [WIDTH-1:0] period_s, duty_s;
   logic             shadow_full;

   // div_d resets to 0, so a high div_clk_in on the first cycle after reset
   // is treated as a rising edge.
   assign tick = div_clk_in & ~div_d;
   assign xfer = cfg_valid & cfg_ready;

   // Outputs are decoded from registers only.
   assign active  = (state_q == RUN);
   assign pwm_out = active && (cnt < duty_a);

   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b1;
      boundary  = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready = 1'b1;
            if (xfer && (cfg_period != '0)) state_d = RUN;
         end
         RUN: begin
            cfg_ready = ~shadow_full;
            boundary  = tick && enable && (cnt == period_a - WIDTH'(1));
            // A pending zero period stops the generator at the boundary.
            if (boundary && shadow_full && (period_s == '0)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_d       <= 1'b0;
         period_done <= 1'b0;
         cnt         <= '0;
         period_a    <= '0;
         duty_a      <= '0;
         period_s    <= '0;
         duty_s      <= '0;
         shadow_full <= 1'b0;
      end else begin
         div_d       <= div_clk_in;
         period_done <= 1'b0;
         case (state_q)
            IDLE: begin
               // A zero-period transfer in IDLE is consumed with no effect.
               if (xfer && (cfg_period != '0)) begin
                  period_a <= cfg_period;
                  duty_a   <= cfg_duty;
                  cnt      <= '0;
               end
            end
            RUN: begin
               // cfg_ready is low while shadow_full is set, so a new transfer
               // never coincides with the shadow being drained below.
               if (xfer) begin
                  period_s    <= cfg_period;
                  duty_s      <= cfg_duty;
                  shadow_full <= 1'b1;
               end
               if (boundary) begin
                  cnt         <= '0;
                  period_done <= 1'b1;
                  if (shadow_full) begin
                     period_a    <= period_s;
                     duty_a      <= duty_s;
                     shadow_full <= 1'b0;
                  end
               end else if (tick && enable) begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_pwm.sv
// -----------------------------------------------------------------------------
// tb_tick_pwm
//
// Directed bench for tick_pwm. Inputs are driven 1 ns after each rising clk
// edge and outputs are checked at that same point. One div_clk_in rising edge
// is produced every 8 clk: high for 4 clk, then low for 4 clk.
// -----------------------------------------------------------------------------
module tb_tick_pwm;

   localparam int W = 8;

   logic         clk;
   logic         reset_n;
   logic         div_clk_in;
   logic         enable;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_period;
   logic [W-1:0] cfg_duty;
   logic         pwm_out;
   logic         period_done;
   logic         active;

   int tests_run = 0;
   int tests_failed = 0;

   tick_pwm #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .div_clk_in (div_clk_in),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .pwm_out    (pwm_out),
      .period_done(period_done),
      .active     (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [W-1:0] p, input logic [W-1:0] d);
      cfg_valid  = 1'b1;
      cfg_period = p;
      cfg_duty   = d;
      step();
      cfg_valid  = 1'b0;
   endtask

   // Rising edge of div_clk_in, sampled at the next clk edge.
   task automatic tick_edge(input logic exp_pwm, input logic exp_done);
      div_clk_in = 1'b1;
      step();
      check("tick_pwm", pwm_out, exp_pwm);
      check("tick_done", period_done, exp_done);
   endtask

   // Remaining 7 clk of one divided-clock cycle; output must stay put.
   task automatic rest7(input logic exp_pwm);
      for (int i = 1; i < 8; i++) begin
         if (i >= 4) div_clk_in = 1'b0;
         step();
         check("hold_pwm", pwm_out, exp_pwm);
         check("hold_done", period_done, 1'b0);
      end
   endtask

   task automatic tick8(input logic exp_pwm, input logic exp_done);
      tick_edge(exp_pwm, exp_done);
      rest7(exp_pwm);
   endtask

   initial begin
      reset_n    = 1'b0;
      div_clk_in = 1'b0;
      enable     = 1'b1;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_duty   = '0;
      step();
      step();
      check("rst_pwm", pwm_out, 1'b0);
      check("rst_done", period_done, 1'b0);
      check("rst_active", active, 1'b0);
      check("rst_ready", cfg_ready, 1'b1);
      reset_n = 1'b1;
      step();

      // Basic waveform: period 4, duty 1.
      do_cfg(8'd4, 8'd1);
      check("start_active", active, 1'b1);
      check("start_pwm", pwm_out, 1'b1);
      check("start_ready", cfg_ready, 1'b1);
      check("start_done", period_done, 1'b0);
      repeat (3) tick8(1'b0, 1'b0);
      tick8(1'b1, 1'b1);
      repeat (3) tick8(1'b0, 1'b0);
      tick8(1'b1, 1'b1);

      // Duty 0, queued through the shadow register.
      do_cfg(8'd4, 8'd0);
      check("shadow_ready_low", cfg_ready, 1'b0);
      repeat (3) tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b1);
      check("duty0_ready", cfg_ready, 1'b1);
      check("duty0_active", active, 1'b1);
      repeat (3) tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b1);

      // Duty 5 above period 4: constant high.
      do_cfg(8'd4, 8'd5);
      repeat (3) tick8(1'b0, 1'b0);
      tick8(1'b1, 1'b1);
      repeat (3) tick8(1'b1, 1'b0);
      tick8(1'b1, 1'b1);

      // Back to 4/1, then reconfigure to 2/1 at tick 1.
      do_cfg(8'd4, 8'd1);
      repeat (3) tick8(1'b1, 1'b0);
      tick8(1'b1, 1'b1);
      tick8(1'b0, 1'b0);
      do_cfg(8'd2, 8'd1);
      check("reconf_ready_low", cfg_ready, 1'b0);
      cfg_valid  = 1'b1;
      cfg_period = 8'd3;
      cfg_duty   = 8'd3;
      check("held_ready_low", cfg_ready, 1'b0);
      tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b0);
      tick_edge(1'b1, 1'b1);
      check("reconf_ready_back", cfg_ready, 1'b1);
      cfg_valid = 1'b0;
      rest7(1'b1);
      tick8(1'b0, 1'b0);
      tick8(1'b1, 1'b1);
      tick8(1'b0, 1'b0);
      tick8(1'b1, 1'b1);

      // Enable freeze with period 4 / duty 2, plus a stop queued while frozen.
      do_cfg(8'd4, 8'd2);
      tick8(1'b0, 1'b0);
      tick8(1'b1, 1'b1);
      check("p4d2_ready", cfg_ready, 1'b1);
      tick8(1'b1, 1'b0);
      enable = 1'b0;
      do_cfg(8'd0, 8'd0);
      check("frozen_handshake", cfg_ready, 1'b0);
      repeat (3) tick8(1'b1, 1'b0);
      enable = 1'b1;
      tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b0);

      // Stop at this boundary.
      tick_edge(1'b0, 1'b1);
      check("stop_active", active, 1'b0);
      check("stop_ready", cfg_ready, 1'b1);
      rest7(1'b0);
      tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b0);
      check("idle_active", active, 1'b0);

      // Zero-period transfer in IDLE is consumed and ignored.
      do_cfg(8'd0, 8'd3);
      check("idle_p0_active", active, 1'b0);
      check("idle_p0_ready", cfg_ready, 1'b1);
      tick8(1'b0, 1'b0);

      // Asynchronous reset right after a boundary, between clk edges.
      do_cfg(8'd4, 8'd2);
      check("rerun_pwm", pwm_out, 1'b1);
      tick8(1'b1, 1'b0);
      tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b0);
      tick_edge(1'b1, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_pwm", pwm_out, 1'b0);
      check("async_done", period_done, 1'b0);
      check("async_active", active, 1'b0);
      check("async_ready", cfg_ready, 1'b1);
      step();
      reset_n = 1'b1;
      step();
      check("post_rst_pwm", pwm_out, 1'b0);
      check("post_rst_done", period_done, 1'b0);
      check("post_rst_active", active, 1'b0);
      div_clk_in = 1'b0;
      step();
      tick8(1'b0, 1'b0);
      tick8(1'b0, 1'b0);
      check("post_rst_idle", active, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
